// File: rtl/iss_regread_pkg.sv
// Shared types for the register-read stage: issue/redirect bundles, the held
// lane payload and the redirect age test used by every lane.
package iss_regread_pkg;

  localparam int IWD  = 2;
  localparam int OPSZ = 64;
  localparam int PRSZ = 128;
  localparam int XLEN = 64;

  // fu bit that marks a memory op (eligible for address-first send)
  localparam int FU_MEM = 1;

  typedef struct packed {
    logic [15:0]      opid;  // bit 15 is the valid flag
    logic [3:0]       fu;
    logic [15:0]      prda;
    logic [1:0][15:0] prsa;
    logic [1:0]       prsb;  // per-source busy
    logic [31:0]      imm;
  } iss_bundle_t;

  typedef struct packed {
    logic [15:0] opid;   // bit 15 is the active flag
    logic [15:0] topid;  // oldest op in flight, reference for age compares
  } red_bundle_t;

  typedef struct packed {
    iss_bundle_t     op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            bval;
  } rr_bundle_t;

  typedef enum logic [1:0] {
    LANE_EMPTY = 2'd0,
    LANE_WAIT  = 2'd1,
    LANE_READY = 2'd2
  } lane_state_e;

  // Younger than the redirect when its distance from topid exceeds the
  // redirect's distance; one extra bit keeps the +1 from wrapping.
  function automatic logic is_younger(input logic [15:0] opid,
                                      input logic [15:0] red_opid,
                                      input logic [15:0] topid,
                                      input logic [15:0] opmask);
    logic [16:0] d_op;
    logic [16:0] d_red;
    d_op  = {1'b0, (opid - topid) & opmask};
    d_red = {1'b0, (red_opid - topid) & opmask} + 17'd1;
    return d_op >= d_red;
  endfunction

endpackage

// File: rtl/iss_regread_rr_lane.sv
// One register-read lane: captures an issued op with bypassed operands, waits
// on busy sources by snooping write-back, and presents it with valid/ack.
module iss_regread_rr_lane
  import iss_regread_pkg::*;
#(
  parameter int nwb  = IWD,
  parameter int opsz = OPSZ
) (
  input  logic                       clk,
  input  logic                       rst,
  input  iss_bundle_t                in_bundle_i,
  input  logic [1:0][XLEN-1:0]       prf_rdata_i,
  input  red_bundle_t                red_bundle_i,
  input  logic [nwb-1:0]             wb_valid_i,
  input  logic [nwb-1:0][15:0]       wb_prda_i,
  input  logic [nwb-1:0][XLEN-1:0]   wb_data_i,
  input  logic                       fu_ack_i,
  output logic                       issue_o,
  output logic                       rr_valid_o,
  output rr_bundle_t                 rr_o,
  output logic [1:0]                 state_o
);

  localparam logic [15:0] OPMASK = 16'(opsz - 1);

  // Handshakes: issue_o/in_bundle_i.opid[15] transfer an op on a clock edge
  // when both are high; rr_valid_o/fu_ack_i transfer the held op likewise.
  // rr_valid_o never drops without an ack except on a redirect flush.

  lane_state_e          state_q;
  rr_bundle_t           rr_q;
  iss_bundle_t          acc_op;
  logic [1:0]           byp_hit;
  logic [1:0]           snp_hit;
  logic [1:0]           busy_in;
  logic [1:0]           busy_wait;
  logic [1:0][XLEN-1:0] byp_val;
  logic [1:0][XLEN-1:0] snp_val;
  logic                 red_act;
  logic                 held_young;
  logic                 in_young;
  logic                 accept;

  always_comb begin
    byp_hit = '0;
    byp_val = '0;
    snp_hit = '0;
    snp_val = '0;
    for (int k = 0; k < 2; k++) begin
      // Register 0 reads as zero and is never busy.
      if (in_bundle_i.prsa[k] == '0) begin
        byp_hit[k] = 1'b1;
      end else begin
        byp_val[k] = prf_rdata_i[k];
        for (int j = nwb - 1; j >= 0; j--) begin
          if (wb_valid_i[j] && (wb_prda_i[j] == in_bundle_i.prsa[k])) begin
            byp_hit[k] = 1'b1;
            byp_val[k] = wb_data_i[j];
          end
        end
      end
      for (int j = nwb - 1; j >= 0; j--) begin
        if (wb_valid_i[j] && (wb_prda_i[j] == rr_q.op.prsa[k])) begin
          snp_hit[k] = 1'b1;
          snp_val[k] = wb_data_i[j];
        end
      end
    end
    busy_in     = in_bundle_i.prsb & ~byp_hit;
    busy_wait   = rr_q.op.prsb & ~snp_hit;
    acc_op      = in_bundle_i;
    acc_op.prsb = busy_in;
  end

  assign red_act    = red_bundle_i.opid[15];
  assign held_young = red_act && is_younger(rr_q.op.opid, red_bundle_i.opid,
                                            red_bundle_i.topid, OPMASK);
  assign in_young   = red_act && is_younger(in_bundle_i.opid, red_bundle_i.opid,
                                            red_bundle_i.topid, OPMASK);
  assign issue_o    = (state_q == LANE_EMPTY) ||
                      ((state_q == LANE_READY) && fu_ack_i);
  assign accept     = in_bundle_i.opid[15] && issue_o && !in_young;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LANE_EMPTY;
      rr_q    <= '0;
    end else if (accept) begin
      rr_q.op <= acc_op;
      rr_q.a  <= byp_val[0];
      rr_q.b  <= byp_val[1];
      if (busy_in == 2'b00) begin
        state_q   <= LANE_READY;
        rr_q.bval <= 1'b1;
      end else if (in_bundle_i.fu[FU_MEM] && (busy_in == 2'b10)) begin
        state_q   <= LANE_READY;
        rr_q.bval <= 1'b0;
      end else begin
        state_q   <= LANE_WAIT;
        rr_q.bval <= 1'b0;
      end
    end else if ((state_q != LANE_EMPTY) && held_young) begin
      state_q <= LANE_EMPTY;
    end else begin
      case (state_q)
        LANE_READY: begin
          if (fu_ack_i) state_q <= LANE_EMPTY;
        end
        LANE_WAIT: begin
          if (rr_q.op.prsb[0] && snp_hit[0]) rr_q.a <= snp_val[0];
          if (rr_q.op.prsb[1] && snp_hit[1]) rr_q.b <= snp_val[1];
          rr_q.op.prsb <= busy_wait;
          if (busy_wait == 2'b00) begin
            state_q   <= LANE_READY;
            rr_q.bval <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rr_valid_o = (state_q == LANE_READY);
  assign rr_o       = rr_q;
  assign state_o    = state_q;

endmodule

// File: rtl/iss_regread.sv
// Operand-fetch stage top: fans out PRF read addresses and the write-back bus
// to one register-read lane per issue slot.
module iss_regread
  import iss_regread_pkg::*;
#(
  parameter int iwd  = IWD,
  parameter int opsz = OPSZ,
  parameter int prsz = PRSZ,
  parameter int xlen = XLEN
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  iss_bundle_t [iwd-1:0]                  iss_bundle_i,
  output logic [iwd-1:0]                         issue_o,
  input  red_bundle_t                            red_bundle_i,
  output logic [iwd-1:0][1:0][$clog2(prsz)-1:0]  prf_raddr_o,
  input  logic [iwd-1:0][1:0][xlen-1:0]          prf_rdata_i,
  input  logic [iwd-1:0]                         wb_valid_i,
  input  logic [iwd-1:0][15:0]                   wb_prda_i,
  input  logic [iwd-1:0][xlen-1:0]               wb_data_i,
  output logic [iwd-1:0]                         rr_valid_o,
  output iss_bundle_t [iwd-1:0]                  rr_bundle_o,
  output logic [iwd-1:0][xlen-1:0]               rr_a_o,
  output logic [iwd-1:0][xlen-1:0]               rr_b_o,
  output logic [iwd-1:0]                         rr_bval_o,
  input  logic [iwd-1:0]                         fu_ack_i,
  output logic [iwd-1:0][1:0]                    lane_state_o
);

  localparam int AW = $clog2(prsz);

  for (genvar i = 0; i < iwd; i++) begin : g_lane
    rr_bundle_t lane_rr;

    assign prf_raddr_o[i][0] = iss_bundle_i[i].prsa[0][AW-1:0];
    assign prf_raddr_o[i][1] = iss_bundle_i[i].prsa[1][AW-1:0];

    iss_regread_rr_lane #(
      .nwb  (iwd),
      .opsz (opsz)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .in_bundle_i  (iss_bundle_i[i]),
      .prf_rdata_i  (prf_rdata_i[i]),
      .red_bundle_i (red_bundle_i),
      .wb_valid_i   (wb_valid_i),
      .wb_prda_i    (wb_prda_i),
      .wb_data_i    (wb_data_i),
      .fu_ack_i     (fu_ack_i[i]),
      .issue_o      (issue_o[i]),
      .rr_valid_o   (rr_valid_o[i]),
      .rr_o         (lane_rr),
      .state_o      (lane_state_o[i])
    );

    assign rr_bundle_o[i] = lane_rr.op;
    assign rr_a_o[i]      = lane_rr.a;
    assign rr_b_o[i]      = lane_rr.b;
    assign rr_bval_o[i]   = lane_rr.bval;
  end

endmodule
